row_span_renderer: RTL and testbench

- Consumer and sequencer for the per-row wall trace interface. Drives the tracer's run strobe and row index, captures the presented side/size at the falling edge of run, and converts them into a horizontal wall span with per-pixel colour for the next display line.
- Screen is rotated, so each display line is one view column. Sits between the VGA sync generator and the colour output stage, alongside the wall tracer.

---
 rtl/row_span_renderer.sv | 142 ++++++++++++++
 tb/tb_row_span_renderer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_span_renderer.sv
// Sequences the per-row wall tracer (run strobe + row index), captures its side/size
// result at the end of each trace line, and renders that span as the next display line.
module row_span_renderer #(
  parameter int unsigned H_VIEW    = 640,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_ROWS    = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned RUN_GAP   = 3,
  parameter logic [5:0]  CEIL_COL  = 6'b010101,
  parameter logic [5:0]  FLOOR_COL = 6'b101010,
  parameter logic [5:0]  WALL_COL0 = 6'b110000,
  parameter logic [5:0]  WALL_COL1 = 6'b100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_side,
  input  logic [10:0] i_size,
  output logic        o_run,
  output logic [9:0]  o_row,
  output logic [5:0]  o_rgb,
  output logic        o_wall
);

  localparam logic [9:0] H_VIEW_W   = 10'(H_VIEW);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] RUN_LAST   = 10'(H_TOTAL - 1 - RUN_GAP);
  localparam logic [9:0] V_ROWS_W   = 10'(V_ROWS);
  localparam logic [9:0] V_ROW_LAST = 10'(V_ROWS - 1);
  localparam logic [9:0] V_PRE_LAST = 10'(V_ROWS - 2);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] CENTER     = 10'(H_VIEW / 2);

  logic        run_q, run_d;
  logic [9:0]  row_q, row_d;
  logic [5:0]  rgb_q, rgb_d;
  logic        wall_q, wall_d;
  logic [10:0] size_q, size_d;
  logic        side_q, side_d;
  logic        valid_q, valid_d;

  logic        trace_line;
  logic        line_end;
  logic        capture;
  logic        clear;
  logic        visible;
  logic [9:0]  half;
  logic [9:0]  span_top;
  logic [9:0]  span_bot;
  logic        in_span;

  // The last blanking line traces row 0; visible lines 0..V_ROWS-2 trace the row below.
  always_comb begin
    trace_line = (i_vpos == V_LAST) || (i_vpos <= V_PRE_LAST);
    line_end   = (i_hpos == H_LAST);
    capture    = trace_line && line_end;
    clear      = (i_vpos == V_ROW_LAST) && line_end;
    visible    = (i_hpos < H_VIEW_W) && (i_vpos < V_ROWS_W);
  end

  always_comb begin
    half = size_q[10:1];
    if (half >= CENTER) begin
      span_top = 10'd0;
      span_bot = H_VIEW_W;
    end else begin
      span_top = CENTER - half;
      span_bot = CENTER + half;
    end
    in_span = valid_q && (i_hpos >= span_top) && (i_hpos < span_bot);
  end

  always_comb begin
    run_d = trace_line && (i_hpos <= RUN_LAST);

    if (trace_line) begin
      if (i_vpos == V_LAST) begin
        row_d = 10'd0;
      end else begin
        row_d = i_vpos + 10'd1;
      end
    end else begin
      row_d = row_q;
    end

    // Clear takes priority; the clearing line is never a trace line anyway.
    if (clear) begin
      size_d  = 11'd0;
      side_d  = side_q;
      valid_d = 1'b0;
    end else if (capture) begin
      size_d  = i_size;
      side_d  = i_side;
      valid_d = 1'b1;
    end else begin
      size_d  = size_q;
      side_d  = side_q;
      valid_d = valid_q;
    end

    if (!visible) begin
      rgb_d  = 6'd0;
      wall_d = 1'b0;
    end else if (in_span) begin
      rgb_d  = side_q ? WALL_COL1 : WALL_COL0;
      wall_d = 1'b1;
    end else if (i_hpos < CENTER) begin
      rgb_d  = CEIL_COL;
      wall_d = 1'b0;
    end else begin
      rgb_d  = FLOOR_COL;
      wall_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      row_q   <= 10'd0;
      rgb_q   <= 6'd0;
      wall_q  <= 1'b0;
      size_q  <= 11'd0;
      side_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      row_q   <= row_d;
      rgb_q   <= rgb_d;
      wall_q  <= wall_d;
      size_q  <= size_d;
      side_q  <= side_d;
      valid_q <= valid_d;
    end
  end

  assign o_run  = run_q;
  assign o_row  = row_q;
  assign o_rgb  = rgb_q;
  assign o_wall = wall_q;

endmodule

// File: tb/tb_row_span_renderer.sv
// Bench for row_span_renderer: drives the line counters directly, keeps a behavioural
// model of the captured span, and checks registered outputs through a scoreboard queue.
module tb_row_span_renderer;

  localparam logic [5:0] CEIL  = 6'b010101;
  localparam logic [5:0] FLOOR = 6'b101010;
  localparam logic [5:0] W0    = 6'b110000;
  localparam logic [5:0] W1    = 6'b100000;
  localparam logic [5:0] BLANK = 6'b000000;

  logic        clk;
  logic        reset;
  logic [9:0]  i_hpos;
  logic [9:0]  i_vpos;
  logic        i_side;
  logic [10:0] i_size;
  logic        o_run;
  logic [9:0]  o_row;
  logic [5:0]  o_rgb;
  logic        o_wall;

  row_span_renderer dut (
    .clk    (clk),
    .reset  (reset),
    .i_hpos (i_hpos),
    .i_vpos (i_vpos),
    .i_side (i_side),
    .i_size (i_size),
    .o_run  (o_run),
    .o_row  (o_row),
    .o_rgb  (o_rgb),
    .o_wall (o_wall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic [9:0] row;
    logic [5:0] rgb;
    logic       wall;
  } exp_t;

  typedef struct {
    int         size;
    logic       side;
    int         hpos;
    logic [5:0] rgb;
    logic       wall;
  } vec_t;

  exp_t q[$];
  int   checks;
  int   failures;

  // Behavioural model of the captured tracer result
  int         m_size;
  logic       m_side;
  logic       m_valid;
  logic [9:0] m_row;

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int   half;
    int   lo;
    int   hi;
    bit   trace;
    e = '0;
    if (reset === 1'b0) return e;
    trace = (v == 524) || (v <= 478);
    e.run = trace && (h <= 796);
    e.row = trace ? ((v == 524) ? 10'd0 : 10'(v + 1)) : m_row;
    if (h < 640 && v < 480) begin
      half = m_size / 2;
      lo = 320 - half;
      if (lo < 0) lo = 0;
      hi = 320 + half;
      if (hi > 640) hi = 640;
      if (m_valid && h >= lo && h < hi) begin
        e.wall = 1'b1;
        e.rgb  = m_side ? W1 : W0;
      end else begin
        e.rgb  = (h < 320) ? CEIL : FLOOR;
      end
    end
    return e;
  endfunction

  task automatic model_update(input int h, input int v);
    bit trace;
    trace = (v == 524) || (v <= 478);
    if (reset === 1'b0) begin
      m_size = 0; m_side = 1'b0; m_valid = 1'b0; m_row = 10'd0;
    end else begin
      if (trace) m_row = (v == 524) ? 10'd0 : 10'(v + 1);
      if (v == 479 && h == 799) begin
        m_valid = 1'b0; m_size = 0;
      end else if (trace && h == 799) begin
        m_size = int'(i_size); m_side = i_side; m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_out(input string name, input int h, input int v);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s h=%0d v=%0d: scoreboard empty", name, h, v);
    end else begin
      e = q.pop_front();
      if (o_run !== e.run || o_row !== e.row || o_rgb !== e.rgb || o_wall !== e.wall) begin
        failures++;
        $display("FAIL %s h=%0d v=%0d got run=%b row=%0d rgb=%b wall=%b required run=%b row=%0d rgb=%b wall=%b",
                 name, h, v, o_run, o_row, o_rgb, o_wall, e.run, e.row, e.rgb, e.wall);
      end
    end
  endtask

  // One clock: present counters, push expectation, advance, compare registered outputs
  task automatic cyc(input string name, input int h, input int v,
                     input bit tab, input logic [5:0] trgb, input logic twall);
    exp_t e;
    i_hpos = 10'(h);
    i_vpos = 10'(v);
    e = model(h, v);
    if (tab) begin
      e.rgb  = trgb;
      e.wall = twall;
    end
    q.push_back(e);
    model_update(h, v);
    @(posedge clk);
    #1;
    check_out(name, h, v);
  endtask

  task automatic span(input string name, input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) cyc(name, h, v, 1'b0, BLANK, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (o_run !== 1'b0 || o_row !== 10'd0 || o_rgb !== 6'd0 || o_wall !== 1'b0) begin
      failures++;
      $display("FAIL %s got run=%b row=%0d rgb=%b wall=%b required all zero",
               name, o_run, o_row, o_rgb, o_wall);
    end
  endtask

  vec_t vecs[20];

  initial begin
    checks = 0; failures = 0;
    m_size = 0; m_side = 1'b0; m_valid = 1'b0; m_row = 10'd0;

    vecs[0]  = '{100,  1'b0, 269, CEIL,  1'b0};
    vecs[1]  = '{100,  1'b0, 270, W0,    1'b1};
    vecs[2]  = '{100,  1'b0, 369, W0,    1'b1};
    vecs[3]  = '{100,  1'b0, 370, FLOOR, 1'b0};
    vecs[4]  = '{100,  1'b0, 640, BLANK, 1'b0};
    vecs[5]  = '{2047, 1'b1, 0,   W1,    1'b1};
    vecs[6]  = '{2047, 1'b1, 639, W1,    1'b1};
    vecs[7]  = '{2047, 1'b1, 700, BLANK, 1'b0};
    vecs[8]  = '{0,    1'b0, 319, CEIL,  1'b0};
    vecs[9]  = '{0,    1'b0, 320, FLOOR, 1'b0};
    vecs[10] = '{1,    1'b1, 320, FLOOR, 1'b0};
    vecs[11] = '{3,    1'b1, 318, CEIL,  1'b0};
    vecs[12] = '{3,    1'b1, 319, W1,    1'b1};
    vecs[13] = '{3,    1'b1, 320, W1,    1'b1};
    vecs[14] = '{3,    1'b1, 321, FLOOR, 1'b0};
    vecs[15] = '{640,  1'b0, 0,   W0,    1'b1};
    vecs[16] = '{638,  1'b0, 0,   CEIL,  1'b0};
    vecs[17] = '{638,  1'b0, 1,   W0,    1'b1};
    vecs[18] = '{638,  1'b0, 638, W0,    1'b1};
    vecs[19] = '{638,  1'b0, 639, FLOOR, 1'b0};

    reset = 1'b0; i_hpos = 10'd0; i_vpos = 10'd0; i_side = 1'b0; i_size = 11'd0;
    #3;
    chk_zero("reset_state");
    span("in_reset", 0, 0, 2);
    reset = 1'b1;

    span("line0_noval", 0, 0, 9);
    span("nontrace479", 479, 0, 5);
    span("blank500", 500, 0, 3);
    span("blank523", 523, 796, 799);

    i_size = 11'd100; i_side = 1'b0;
    span("trace524", 524, 0, 799);
    span("render100", 0, 0, 799);

    for (int i = 0; i < 20; i++) begin
      i_size = 11'(vecs[i].size);
      i_side = vecs[i].side;
      cyc("cap_vec", 799, 524, 1'b0, BLANK, 1'b0);
      cyc("probe_vec", vecs[i].hpos, 0, 1'b1, vecs[i].rgb, vecs[i].wall);
    end

    i_size = 11'd50; i_side = 1'b1;
    span("trace478", 478, 790, 799);
    span("line479", 479, 0, 799);
    span("blank480", 480, 0, 5);
    span("after_clear", 0, 290, 300);

    i_size = 11'd0; i_side = 1'b0;
    i_size = 11'd200;
    span("capture_pre", 524, 799, 799);
    span("pre_reset10", 10, 390, 400);
    i_hpos = 10'd401;
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    span("hold_reset", 10, 401, 499);
    reset = 1'b1;
    i_size = 11'd0;
    span("release10", 10, 500, 799);
    span("line11", 11, 0, 20);
    span("line11_mid", 11, 315, 325);

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got %0d entries required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
